counter_bank_driver: RTL
========================

Name: counter_bank_driver

Overview:
- Stimulus/checker for the parallel 16-bit counter bank STA design.
- Drives the bank's `cen` enable vector and monitors its single `cout` response.
- Verifies the first-response latency and the number of `cout` pulses against values derived from the bank's pipeline depth.
- Sits in the test harness, directly wired to the bank's `cen`/`cout` pins, on the same clock.

Parameters:
- LANES, 32, width of `cen` (number of counters in the bank)
- CNT_W, 16, counter width in the bank
- SYNC_STAGES, 2, enable synchroniser depth in the bank
- PCNT_W, 16, width of the pulse counter

Ports:
- clock  in  1  single clock, rising edge, shared with the bank
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle run request; ignored while busy
- lane_mask  in  LANES  lanes to enable for the run; sampled on accepted start
- hold_len  in  32  number of cycles `cen` is held at lane_mask; sampled on accepted start
- cen  out  LANES  registered enable vector to the bank
- cout  in  1  bank response
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run; valid from done until the next start
- err_code  out  2  0 ok, 1 latency mismatch, 2 pulse-count mismatch, 3 cout high at end of run
- lat_meas  out  32  cycles from first DRIVE cycle to first `cout` high; all-ones if no pulse was seen
- pulse_cnt  out  PCNT_W  `cout` rising edges seen during DRIVE plus DRAIN; saturating

Behaviour:
- Reset (`reset_n` low at a clock edge):
  - cen=0, busy=0, done=0, pass=0, err_code=0, lat_meas=all-ones, pulse_cnt=0, state IDLE.
  - Reset during a run aborts it immediately. cen drops on that same edge; no done pulse is issued.
- Derived constants:
  - FULL = 2^CNT_W - 1
  - EXP_LAT = SYNC_STAGES + FULL + 2
  - DRAIN_LEN = SYNC_STAGES + 3
  - EXP_PULSES = floor((hold_len + 1) / 2^CNT_W), computed on a 33-bit sum, then saturated to PCNT_W.
  - With defaults: EXP_LAT = 65539, DRAIN_LEN = 5.
- State machine:
  - IDLE: on start, latch lane_mask and hold_len, busy=1, clear pulse_cnt and lat_meas, go to CLEAR.
  - CLEAR: cen=0 for DRAIN_LEN cycles. This zeroes all bank counters so every lane starts in phase. Then go to DRIVE, or directly to DRAIN if hold_len==0 or lane_mask==0.
  - DRIVE: cen=lane_mask for exactly hold_len cycles. The cycle counter starts at 0 on the first DRIVE cycle, and lat_meas captures its value on the first `cout`=1. Then go to DRAIN.
  - DRAIN: cen=0 for DRAIN_LEN cycles. `cout` pulses are still counted and the latency counter keeps running. Then go to CHECK.
  - CHECK: one cycle. Compute pass/err_code, pulse done=1, busy=0, go to IDLE.
- Pulse counting:
  - Count rising edges of `cout`, using a previous-value register cleared in CLEAR.
  - Each enabled lane wraps FULL→0, so a correct bank gives one-cycle `cout` pulses, 2^CNT_W cycles apart.
- Checks in CHECK, applied in priority order:
  - `cout`=1 → err 3.
  - pulse_cnt != EXP_PULSES → err 2. EXP_PULSES is forced to 0 when lane_mask==0.
  - EXP_PULSES>0 and lat_meas != EXP_LAT → err 1.
  - Otherwise err 0.
  - pass = (err_code==0).
- Counter rules:
  - The latency counter is 32-bit and saturates at all-ones.
  - pulse_cnt saturates at 2^PCNT_W-1.
- start while busy is ignored, with no side effects. start in the same cycle as reset_n low is ignored.
- `cen` is always driven from a flop; no combinational path from any input to `cen`.

Optional Feature:
- Macro: CEN_LFSR_EN.
- When defined:
  - A LANES-bit Galois LFSR (seed all-ones after reset) replaces lane_mask as the driven mask.
  - The LFSR advances once per accepted start, and the mask used is exposed through the same internal latch.
  - A mask of 0 is never produced.
- When undefined: lane_mask is used as sampled, and no LFSR logic is present.

Decomposition:
- Shared package (counter_bank_pkg):
  - state enum: IDLE, CLEAR, DRIVE, DRAIN, CHECK.
  - err_code constants.
  - functions for EXP_LAT, DRAIN_LEN and EXP_PULSES from parameters.
- One natural sub-module: cout_monitor, which handles edge detection, the saturating pulse counter and first-rise latency capture.

Test Plan:
- Single lane: lane_mask=0x1, hold_len=65535 → one cout pulse, lat_meas=65539, pulse_cnt=1, pass=1, err=0.
- All lanes: lane_mask=0xFFFFFFFF, hold_len=200000 → pulse_cnt=3, lat_meas=65539, pass=1.
- Short hold: hold_len=65534, lane_mask=0x80000000 → pulse_cnt=0, lat_meas=all-ones, pass=1. Zero hold: hold_len=0 → DRIVE skipped, pass=1, done 2*DRAIN_LEN+1 cycles after start.
- Faulty model: bank model with a 3-stage synchroniser, hold_len=65535 → lat_meas=65540, err=1, pass=0. Stuck-high cout model → err=3.
- Reset mid-DRIVE at cycle 1000 → cen=0 on the next edge, busy=0, no done pulse; a new start afterwards completes with pass=1 (CLEAR stage restores lane phase).
- start pulsed while busy at cycles 10 and 500 → ignored; exactly one done pulse and unchanged lane_mask latch. With CEN_LFSR_EN: two consecutive runs use different nonzero masks.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// Shared types, constants and derived-value helpers for the counter bank driver.
package counter_bank_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_DRIVE = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_CHECK = 3'd4;

  localparam logic [1:0] ERR_OK        = 2'd0;
  localparam logic [1:0] ERR_LATENCY   = 2'd1;
  localparam logic [1:0] ERR_PULSE_CNT = 2'd2;
  localparam logic [1:0] ERR_COUT_HIGH = 2'd3;

  // Low feedback taps of the mask LFSR; the top tap is always forced on.
  localparam logic [31:0] LFSR_LOW_TAPS = 32'h0020_0003;

  // Cycles from the first driven cycle to the first cout of a healthy bank.
  function automatic logic [31:0] exp_lat(input int unsigned sync_stages,
                                          input int unsigned cnt_w);
    return 32'(sync_stages) + ((32'd1 << cnt_w) - 32'd1) + 32'd2;
  endfunction

  // Idle cycles needed to flush the bank synchroniser and zero its counters.
  function automatic logic [31:0] drain_len(input int unsigned sync_stages);
    return 32'(sync_stages) + 32'd3;
  endfunction

  // Expected wrap count for a hold of 'hold' cycles, saturated to pcnt_w bits.
  function automatic logic [31:0] exp_pulses(input logic [31:0] hold,
                                             input int unsigned cnt_w,
                                             input int unsigned pcnt_w);
    logic [32:0] sum;
    logic [32:0] quo;
    logic [32:0] cap;
    sum = {1'b0, hold} + 33'd1;
    quo = sum >> cnt_w;
    cap = (33'd1 << pcnt_w) - 33'd1;
    if (quo > cap) quo = cap;
    return quo[31:0];
  endfunction

endpackage

// File: rtl/cout_monitor.sv
// Watches the bank's cout: rising-edge pulse counter and first-rise latency.
module cout_monitor
  import counter_bank_pkg::*;
#(
  parameter int unsigned PCNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              arm,
  input  logic              active,
  input  logic              cout,
  output logic [PCNT_W-1:0] pulse_cnt,
  output logic [31:0]       lat_meas
);

  logic              prev_q, prev_d;
  logic              seen_q, seen_d;
  logic [31:0]       lat_cnt_q, lat_cnt_d;
  logic [31:0]       lat_meas_q, lat_meas_d;
  logic [PCNT_W-1:0] pulse_q, pulse_d;

  // Next-state: edge detect, saturating counters, first-rise capture.
  always_comb begin
    prev_d     = cout;
    seen_d     = seen_q;
    lat_cnt_d  = lat_cnt_q;
    lat_meas_d = lat_meas_q;
    pulse_d    = pulse_q;

    if (arm) begin
      prev_d    = 1'b0;
      lat_cnt_d = '0;
    end else if (active && (lat_cnt_q != '1)) begin
      lat_cnt_d = lat_cnt_q + 32'd1;
    end

    if (clear) begin
      pulse_d    = '0;
      lat_meas_d = '1;
      seen_d     = 1'b0;
    end else if (active) begin
      if (cout && !prev_q && (pulse_q != '1)) pulse_d = pulse_q + PCNT_W'(1);
      if (cout && !seen_q) begin
        lat_meas_d = lat_cnt_q;
        seen_d     = 1'b1;
      end
    end
  end

  // Monitor registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prev_q     <= 1'b0;
      seen_q     <= 1'b0;
      lat_cnt_q  <= '0;
      lat_meas_q <= '1;
      pulse_q    <= '0;
    end else begin
      prev_q     <= prev_d;
      seen_q     <= seen_d;
      lat_cnt_q  <= lat_cnt_d;
      lat_meas_q <= lat_meas_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse_cnt = pulse_q;
  assign lat_meas  = lat_meas_q;

endmodule

// File: rtl/counter_bank_driver.sv
// Stimulus/checker for the parallel counter bank: drives cen, checks cout.
// Optional feature: define CEN_LFSR_EN to drive an LFSR-generated lane mask.
module counter_bank_driver
  import counter_bank_pkg::*;
#(
  parameter int unsigned LANES       = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PCNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [LANES-1:0]  lane_mask,
  input  logic [31:0]       hold_len,
  output logic [LANES-1:0]  cen,
  input  logic              cout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code,
  output logic [31:0]       lat_meas,
  output logic [PCNT_W-1:0] pulse_cnt
);

  localparam logic [31:0] EXP_LAT    = exp_lat(SYNC_STAGES, CNT_W);
  localparam logic [31:0] DRAIN_LEN  = drain_len(SYNC_STAGES);
  localparam logic [31:0] DRAIN_LAST = DRAIN_LEN - 32'd1;

  state_t            state_q, state_d;
  logic [31:0]       phase_q, phase_d;
  logic [LANES-1:0]  mask_q, mask_d;
  logic [31:0]       hold_q, hold_d;
  logic [LANES-1:0]  cen_q, cen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [1:0]        err_q, err_d;

  logic              start_acc_c;
  logic              arm_c;
  logic              active_c;
  logic [PCNT_W-1:0] exp_pulses_c;
  logic [LANES-1:0]  run_mask_c;

`ifdef CEN_LFSR_EN
  localparam logic [LANES-1:0] LFSR_TAPS = {1'b1, (LANES-1)'(LFSR_LOW_TAPS)};

  logic [LANES-1:0] lfsr_q, lfsr_d;
  logic [LANES-1:0] unused_lane_mask;

  assign unused_lane_mask = lane_mask;

  // Galois step per accepted start; the forced top tap keeps it nonzero.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start_acc_c) lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  end

  // LFSR register, seeded all-ones.
  always_ff @(posedge clock) begin
    if (!reset_n) lfsr_q <= '1;
    else          lfsr_q <= lfsr_d;
  end

  assign run_mask_c = lfsr_d;
`else
  assign run_mask_c = lane_mask;
`endif

  assign arm_c    = (state_q == ST_CLEAR);
  assign active_c = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);

  // Expected wrap count for the latched run; no enabled lanes means none.
  always_comb begin
    exp_pulses_c = '0;
    if (mask_q != '0) exp_pulses_c = PCNT_W'(exp_pulses(hold_q, CNT_W, PCNT_W));
  end

  // Run sequencer: next state, phase counter, result evaluation.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 32'd1;
    mask_d      = mask_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    cen_d       = '0;
    start_acc_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start) begin
          start_acc_c = 1'b1;
          state_d     = ST_CLEAR;
          mask_d      = run_mask_c;
          hold_d      = hold_len;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = ERR_OK;
        end
      end
      ST_CLEAR: begin
        if (phase_q == DRAIN_LAST) begin
          phase_d = '0;
          if ((hold_q == '0) || (mask_q == '0)) state_d = ST_DRAIN;
          else                                  state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (phase_q == (hold_q - 32'd1)) begin
          phase_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (phase_q == DRAIN_LAST) begin
          phase_d = '0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        phase_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (cout)                                           err_d = ERR_COUT_HIGH;
        else if (pulse_cnt != exp_pulses_c)                 err_d = ERR_PULSE_CNT;
        else if ((exp_pulses_c != '0) && (lat_meas != EXP_LAT)) err_d = ERR_LATENCY;
        else                                                err_d = ERR_OK;
        pass_d = (err_d == ERR_OK);
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (state_d == ST_DRIVE) cen_d = mask_q;
  end

  // Sequencer registers; reset aborts any run and drops cen on the same edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
      cen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
      cen_q   <= cen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
    end
  end

  cout_monitor #(
    .PCNT_W (PCNT_W)
  ) u_cout_monitor (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (start_acc_c),
    .arm       (arm_c),
    .active    (active_c),
    .cout      (cout),
    .pulse_cnt (pulse_cnt),
    .lat_meas  (lat_meas)
  );

  assign cen      = cen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_q;

endmodule
